// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file (32 x 64, X31 reads as zero).
package register_file_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_STORED = NUM_REGS - 1;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(NUM_REGS - 1);

  // Gate delay and bench step from the shared delays include
  localparam int unsigned GATE_DELAY      = 1;
  localparam int unsigned TESTBENCH_DELAY = 5;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/register_file_if.sv
// Write-back / decode bus of the register file: one write port and two read ports.
interface register_file_if;
  import register_file_pkg::*;

  logic  RegWrite;
  addr_t WriteRegister;
  data_t WriteData;
  addr_t ReadRegister1;
  addr_t ReadRegister2;
  data_t ReadData1;
  data_t ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/register_file_decoder5_32.sv
// Enabled 5:32 one-hot decoder: a 2:4 stage on sel[4:3] enabling four 3:8 stages on sel[2:0].
module register_file_decoder5_32 (
    input  logic [4:0]  sel,
    input  logic        en,
    output logic [31:0] out
);

    logic [3:0] grp_en;

    always_comb begin
        grp_en = '0;
        if (en) begin
            grp_en[sel[4:3]] = 1'b1;
        end
        out = '0;
        for (int g = 0; g < 4; g++) begin
            if (grp_en[g]) begin
                out[g * 8 + int'(sel[2:0])] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: X0..X30 stored, X31 hardwired to zero, two combinational reads.
// Optional same-cycle write-to-read bypass under REGFILE_WRITE_BYPASS_EN.
module register_file
    import register_file_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    register_file_if.slave   bus
);

    logic [NUM_REGS-1:0] load_en;
    data_t               regs_q [NUM_STORED];
    data_t               regs_d [NUM_STORED];
    data_t               rd_view [NUM_REGS];
    logic                unused_load_en_zero;

    register_file_decoder5_32 u_wr_dec (
        .sel (bus.WriteRegister),
        .en  (bus.RegWrite),
        .out (load_en)
    );

    // X31 has no storage, so its load enable goes nowhere
    assign unused_load_en_zero = load_en[NUM_REGS-1];

    always_comb begin
        for (int i = 0; i < NUM_STORED; i++) begin
            regs_d[i] = load_en[i] ? bus.WriteData : regs_q[i];
            if (reset) begin
                regs_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_STORED; i++) begin
            rd_view[i] = regs_q[i];
        end
        rd_view[NUM_REGS-1] = '0;
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic byp1, byp2;

    always_comb begin
        byp1 = bus.RegWrite && !reset && (bus.WriteRegister == bus.ReadRegister1)
               && (bus.ReadRegister1 != ZERO_REG);
        byp2 = bus.RegWrite && !reset && (bus.WriteRegister == bus.ReadRegister2)
               && (bus.ReadRegister2 != ZERO_REG);
        bus.ReadData1 = byp1 ? bus.WriteData : rd_view[bus.ReadRegister1];
        bus.ReadData2 = byp2 ? bus.WriteData : rd_view[bus.ReadRegister2];
    end
`else
    always_comb begin
        bus.ReadData1 = rd_view[bus.ReadRegister1];
        bus.ReadData2 = rd_view[bus.ReadRegister2];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases then random traffic against an array model.
module tb_register_file;
    import register_file_pkg::*;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [63:0] model [32];

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #(TESTBENCH_DELAY) clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expect_read(input int idx);
        if (idx == 31) return 64'h0;
        if (Bypass && bus.RegWrite && !reset && int'(bus.WriteRegister) == idx) return bus.WriteData;
        return model[idx];
    endfunction

    task automatic drive(input logic we, input int wr, input logic [63:0] wd,
                         input int r1, input int r2);
        bus.RegWrite      = we;
        bus.WriteRegister = 5'(wr);
        bus.WriteData     = wd;
        bus.ReadRegister1 = 5'(r1);
        bus.ReadRegister2 = 5'(r2);
    endtask

    task automatic check_reads(input string tag);
        #(GATE_DELAY);
        check({tag, "/rd1"}, bus.ReadData1, expect_read(int'(bus.ReadRegister1)));
        check({tag, "/rd2"}, bus.ReadData2, expect_read(int'(bus.ReadRegister2)));
    endtask

    // One rising edge; the model applies the architectural update rule
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (bus.RegWrite && bus.WriteRegister != 5'd31) begin
            model[int'(bus.WriteRegister)] = bus.WriteData;
        end
        #(GATE_DELAY);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b1;
        drive(1'b0, 0, 64'h0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 64'h0, 0, 30);
        check_reads("reset_state_0_30");
        drive(1'b0, 0, 64'h0, 17, 31);
        check_reads("reset_state_17_31");

        // Reset clears a written register
        drive(1'b1, 5, 64'hDEAD, 5, 0);
        tick();
        bus.RegWrite = 1'b0;
        check("x5_written", bus.ReadData1, 64'hDEAD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_x5", bus.ReadData1, 64'h0);
        check("reset_x0", bus.ReadData2, 64'h0);

        // Write all then read symmetric pairs
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, i, 64'(i) * 64'h0101010101010101, 0, 0);
            tick();
        end
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 0, 64'h0, i, 30 - i);
            #(GATE_DELAY);
            check($sformatf("pair_%0d_rd1", i), bus.ReadData1, 64'(i) * 64'h0101010101010101);
            check($sformatf("pair_%0d_rd2", i), bus.ReadData2,
                  64'(30 - i) * 64'h0101010101010101);
        end

        // X31 ignores writes
        drive(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
        tick();
        bus.RegWrite = 1'b0;
        #(GATE_DELAY);
        check("x31_rd1", bus.ReadData1, 64'h0);
        check("x31_rd2", bus.ReadData2, 64'h0);

        // Enable gating
        drive(1'b1, 7, 64'hAAAA, 7, 7);
        tick();
        drive(1'b0, 7, 64'h1234, 7, 7);
        tick();
        check("gated_x7", bus.ReadData1, 64'hAAAA);

        // Reset beats a same-edge write
        drive(1'b1, 3, 64'h99, 3, 3);
        tick();
        reset = 1'b1;
        drive(1'b1, 3, 64'h55, 3, 3);
        tick();
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        #(GATE_DELAY);
        check("reset_priority_x3", bus.ReadData1, 64'h0);

        // Same-cycle read/write of X9
        drive(1'b1, 9, 64'h10, 9, 9);
        tick();
        drive(1'b1, 9, 64'h20, 9, 9);
        #(GATE_DELAY);
        check("x9_before_edge_rd1", bus.ReadData1, Bypass ? 64'h20 : 64'h10);
        check("x9_before_edge_rd2", bus.ReadData2, Bypass ? 64'h20 : 64'h10);
        tick();
        bus.RegWrite = 1'b0;
        #(GATE_DELAY);
        check("x9_after_edge", bus.ReadData1, 64'h20);

        // Dual-port same index, then move to an empty register
        drive(1'b1, 12, 64'h0F0F, 12, 12);
        tick();
        bus.RegWrite = 1'b0;
        #(GATE_DELAY);
        check("dual_x12_rd1", bus.ReadData1, 64'h0F0F);
        check("dual_x12_rd2", bus.ReadData2, 64'h0F0F);
        bus.ReadRegister1 = 5'd13;
        bus.ReadRegister2 = 5'd13;
        #(GATE_DELAY);
        check("dual_x13_rd1", bus.ReadData1, 64'h0);
        check("dual_x13_rd2", bus.ReadData2, 64'h0);

        // Random traffic, occasionally reset, reads biased towards the write index
        for (int n = 0; n < 400; n++) begin
            logic [63:0] wd;
            int wr;
            wd = {$urandom, $urandom};
            wr = int'($urandom_range(0, 31));
            reset = ($urandom_range(0, 31) == 0);
            drive(1'(($urandom & 32'd3) != 0), wr, wd,
                  ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
            check_reads($sformatf("rand_%0d_pre", n));
            tick();
            reset = 1'b0;
            check_reads($sformatf("rand_%0d_post", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
